timer_scheduler: RTL and testbench

Multi-channel timer scheduler built on one shared prescaler. A single free-running prescaler turns the 50 MHz board clock into a one-cycle base tick (default 250 ms). NCH independent countdown channels count that tick, and each is configured through a valid/ready port to fire one-shot or periodic expiry pulses. The block sits between the board clock and the user-level sequencing logic (LED/display stepping, debounce windows, game timing), replacing per-consumer clock dividers with tick enables on one clock.

---
 rtl/timer_scheduler_pkg.sv | 35 +++
 rtl/timer_scheduler_if.sv | 34 +++
 rtl/timer_scheduler_tick_prescaler.sv | 36 +++
 rtl/timer_scheduler.sv | 167 ++++++++++++++++
 tb/tb_timer_scheduler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/timer_scheduler_pkg.sv
// Shared types and helpers for the timer scheduler.
// Contents: channel state enum, config request struct, and the functions
// that derive the prescaler divide ratio and its counter width.
package timer_sched_pkg;

  // The struct is sized for the largest legal build (16 channels, 32-bit
  // periods). Narrower builds zero-extend into it.
  localparam int CFG_CH_W  = 4;
  localparam int CFG_CNT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [CFG_CH_W-1:0]  ch;
    logic                 start;
    logic                 periodic;
    logic [CFG_CNT_W-1:0] period;
  } cfg_req_t;

  // Clock cycles per base tick.
  function automatic int calc_prescale(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Width of a counter running 0..PRESCALE-1, never below one bit.
  function automatic int calc_prescale_w(input int clk_hz, input int tick_hz);
    int p;
    p = clk_hz / tick_hz;
    return (p > 2) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/timer_scheduler_if.sv
// Configuration port of the timer scheduler: a valid/ready request that
// selects a channel and either starts it with a period or stops it.
// master = requester, slave = scheduler.
interface timer_scheduler_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic             cfg_start;
  logic             cfg_periodic;
  logic [CNT_W-1:0] cfg_period;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_start,
    output cfg_periodic,
    output cfg_period,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_start,
    input  cfg_periodic,
    input  cfg_period,
    output cfg_ready
  );
endinterface

// File: rtl/timer_scheduler_tick_prescaler.sv
// Free-running prescaler: divides the board clock by PRESCALE and emits a
// registered one-cycle base tick in the cycle after the counter reaches
// PRESCALE-1.
module tick_prescaler
  import timer_sched_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 4
) (
  input  logic clk_in,
  input  logic reset,
  output logic o_base_tick
);
  localparam int PRESCALE = calc_prescale(CLK_HZ, TICK_HZ);
  localparam int PRESC_W  = calc_prescale_w(CLK_HZ, TICK_HZ);
  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] r_cnt;
  logic               r_base_tick;
  logic               w_at_last;

  assign w_at_last   = (r_cnt == LAST);
  assign o_base_tick = r_base_tick;

  // Count 0..PRESCALE-1 and register the wrap as the tick pulse.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_cnt       <= '0;
      r_base_tick <= 1'b0;
    end else begin
      r_base_tick <= w_at_last;
      r_cnt       <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel timer scheduler: one shared prescaler feeds NCH countdown
// channels, each configured over a valid/ready port for one-shot or
// periodic expiry pulses.
// Optional feature macro: TIMER_SCHED_STICKY_EN adds sticky expire_flag
// outputs cleared by flag_ack (a set beats a simultaneous ack).
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 4,
  parameter int NCH     = 4,
  parameter int CNT_W   = 16
) (
  input  logic                clk_in,
  input  logic                reset,
  timer_scheduler_if.slave    cfg,
  output logic                base_tick,
  output logic [NCH-1:0]      expire,
  output logic [NCH-1:0]      busy
`ifdef TIMER_SCHED_STICKY_EN
  ,
  output logic [NCH-1:0]      expire_flag,
  input  logic [NCH-1:0]      flag_ack
`endif
);

  logic           w_base_tick;
  logic           r_cfg_ready;
  logic           w_accept;
  logic           w_load;
  cfg_req_t       w_req;
  logic [NCH-1:0] w_hit;

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_prescaler (
    .clk_in      (clk_in),
    .reset       (reset),
    .o_base_tick (w_base_tick)
  );

  assign base_tick     = w_base_tick;
  assign cfg.cfg_ready = r_cfg_ready;
  assign w_accept      = cfg.cfg_valid & r_cfg_ready;

  // Widen the request fields into the package struct.
  always_comb begin
    w_req          = '0;
    w_req.ch       = CFG_CH_W'(cfg.cfg_ch);
    w_req.start    = cfg.cfg_start;
    w_req.periodic = cfg.cfg_periodic;
    w_req.period   = CFG_CNT_W'(cfg.cfg_period);
  end

  // A zero period is treated as a stop.
  assign w_load = w_req.start & (w_req.period != '0);

  // Ready drops for one cycle after each accept, spacing accepts 2 apart.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_cfg_ready <= 1'b0;
    end else begin
      r_cfg_ready <= ~w_accept;
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      ch_state_e        r_state;
      ch_state_e        w_state_next;
      logic [CNT_W-1:0] r_remaining;
      logic [CNT_W-1:0] w_remaining_next;
      logic [CNT_W-1:0] r_period;
      logic [CNT_W-1:0] w_period_next;
      logic             r_periodic;
      logic             w_periodic_next;
      logic             r_expire;
      logic             w_expire_next;
      logic             w_busy;

      assign w_hit[gi] = w_accept & (w_req.ch == CFG_CH_W'(gi));

      // Channel state register with its counter, period and mode.
      always_ff @(posedge clk_in) begin
        if (reset) begin
          r_state     <= IDLE;
          r_remaining <= '0;
          r_period    <= '0;
          r_periodic  <= 1'b0;
          r_expire    <= 1'b0;
        end else begin
          r_state     <= w_state_next;
          r_remaining <= w_remaining_next;
          r_period    <= w_period_next;
          r_periodic  <= w_periodic_next;
          r_expire    <= w_expire_next;
        end
      end

      // Next state: a config accept overrides any tick in the same cycle.
      always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_period_next    = r_period;
        w_periodic_next  = r_periodic;
        w_expire_next    = 1'b0;
        if (w_hit[gi]) begin
          if (w_load) begin
            w_state_next     = RUN;
            w_remaining_next = w_req.period[CNT_W-1:0];
            w_period_next    = w_req.period[CNT_W-1:0];
            w_periodic_next  = w_req.periodic;
          end else begin
            w_state_next     = IDLE;
            w_remaining_next = '0;
          end
        end else begin
          case (r_state)
            RUN: begin
              if (w_base_tick) begin
                if (r_remaining == CNT_W'(1)) begin
                  w_expire_next = 1'b1;
                  if (r_periodic) begin
                    w_remaining_next = r_period;
                  end else begin
                    w_state_next     = IDLE;
                    w_remaining_next = '0;
                  end
                end else begin
                  w_remaining_next = r_remaining - 1'b1;
                end
              end
            end
            default: begin
              w_state_next = IDLE;
            end
          endcase
        end
      end

      // Outputs: busy follows the state, expire is the registered pulse.
      always_comb begin
        w_busy = (r_state == RUN);
      end

      assign busy[gi]   = w_busy;
      assign expire[gi] = r_expire;
    end
  endgenerate

`ifdef TIMER_SCHED_STICKY_EN
  logic [NCH-1:0] r_expire_flag;

  // Sticky flags: an expire pulse sets, an ack clears, set has priority.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_expire_flag <= '0;
    end else begin
      r_expire_flag <= (r_expire_flag & ~flag_ack) | expire;
    end
  end

  assign expire_flag = r_expire_flag;
`endif

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed testbench for timer_scheduler with PRESCALE = 10 (40 Hz / 4 Hz).
// cyc counts clock edges since the last reset release; outputs are sampled
// 1 time unit after each rising edge.
module tb_timer_scheduler;

  logic       clk_in;
  logic       reset;
  logic       base_tick;
  logic [3:0] expire;
  logic [3:0] busy;
`ifdef TIMER_SCHED_STICKY_EN
  logic [3:0] expire_flag;
  logic [3:0] flag_ack;
`endif

  int n_checks;
  int n_errors;
  int cyc;

  timer_scheduler_if #(.NCH(4), .CNT_W(16)) cfg_if ();

  timer_scheduler #(
    .CLK_HZ  (40),
    .TICK_HZ (4),
    .NCH     (4),
    .CNT_W   (16)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .cfg         (cfg_if),
    .base_tick   (base_tick),
    .expire      (expire),
    .busy        (busy)
`ifdef TIMER_SCHED_STICKY_EN
    ,
    .expire_flag (expire_flag),
    .flag_ack    (flag_ack)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s at cyc %0d: observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic send(input logic [1:0] ch, input logic start, input logic periodic,
                      input logic [15:0] per);
    cfg_if.cfg_valid    = 1'b1;
    cfg_if.cfg_ch       = ch;
    cfg_if.cfg_start    = start;
    cfg_if.cfg_periodic = periodic;
    cfg_if.cfg_period   = per;
    step();
    cfg_if.cfg_valid    = 1'b0;
    $display("cyc %0d: cfg ch=%0d start=%0d periodic=%0d period=%0d", cyc, ch, start, periodic, per);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    reset    = 1'b1;
    cfg_if.cfg_valid    = 1'b0;
    cfg_if.cfg_ch       = '0;
    cfg_if.cfg_start    = 1'b0;
    cfg_if.cfg_periodic = 1'b0;
    cfg_if.cfg_period   = '0;
`ifdef TIMER_SCHED_STICKY_EN
    flag_ack = '0;
`endif

    // Reset state
    step(); step(); step();
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
    check("rst_tick", 32'(base_tick), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_expire", 32'(expire), 32'd0);
`ifdef TIMER_SCHED_STICKY_EN
    check("rst_flag", 32'(expire_flag), 32'd0);
`endif

    // Prescaler after release: ticks at 10, 20, 30
    reset = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      check("tick_phase", 32'(base_tick), (k % 10 == 0) ? 32'd1 : 32'd0);
      if (k < 10) begin
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_expire", 32'(expire), 32'd0);
      end
      if (k == 1) check("ready_after_rst", 32'(cfg_if.cfg_ready), 32'd1);
    end

    // Ch0 one-shot period 3, accepted just after the tick at cycle 30
    goto(31);
    send(2'd0, 1'b1, 1'b0, 16'd3);
    check("os_busy_rise", 32'(busy), 32'b0001);
    check("ready_gap", 32'(cfg_if.cfg_ready), 32'd0);
    step();
    check("ready_back", 32'(cfg_if.cfg_ready), 32'd1);

    // Ch1 periodic period 2: expires at 51, 71, 91
    send(2'd1, 1'b1, 1'b1, 16'd2);
    check("per_busy_rise", 32'(busy), 32'b0011);
    goto(50); check("exp_50", 32'(expire), 32'd0);
    goto(51); check("exp_51", 32'(expire), 32'b0010);
    check("busy_51", 32'(busy), 32'b0011);
    goto(52); check("exp_52", 32'(expire), 32'd0);
    goto(60); check("exp_60", 32'(expire), 32'd0);
    check("busy_60", 32'(busy), 32'b0011);
    goto(61); check("os_expire", 32'(expire), 32'b0001);
    check("os_busy_fall", 32'(busy), 32'b0010);
    goto(62); check("exp_62", 32'(expire), 32'd0);
    goto(71); check("per_exp_71", 32'(expire), 32'b0010);

    // Ch0 one-shot period 2 so it is counting across the cycle-80 tick
    goto(72);
    send(2'd0, 1'b1, 1'b0, 16'd2);
    check("busy_73", 32'(busy), 32'b0011);

    // Ch2 accepted on the tick edge, ch3 back-to-back behind it
    goto(80);
    check("tick_80", 32'(base_tick), 32'd1);
    cfg_if.cfg_valid    = 1'b1;
    cfg_if.cfg_ch       = 2'd2;
    cfg_if.cfg_start    = 1'b1;
    cfg_if.cfg_periodic = 1'b0;
    cfg_if.cfg_period   = 16'd1;
    step();
    $display("cyc %0d: cfg ch=2 start=1 periodic=0 period=1 (on tick edge)", cyc);
    check("b2b_ready0", 32'(cfg_if.cfg_ready), 32'd0);
    check("b2b_busy81", 32'(busy), 32'b0111);
    cfg_if.cfg_ch       = 2'd3;
    cfg_if.cfg_periodic = 1'b1;
    cfg_if.cfg_period   = 16'd5;
    step();
    check("b2b_ready1", 32'(cfg_if.cfg_ready), 32'd1);
    check("b2b_held", 32'(busy), 32'b0111);
    check("exp_82", 32'(expire), 32'd0);
    step();
    cfg_if.cfg_valid = 1'b0;
    $display("cyc %0d: cfg ch=3 start=1 periodic=1 period=5 (second request)", cyc);
    check("b2b_accept2", 32'(busy), 32'b1111);
    check("b2b_ready_gap", 32'(cfg_if.cfg_ready), 32'd0);

    // Ch0, ch1 and ch2 all expire at 91
    goto(90); check("exp_90", 32'(expire), 32'd0);
    goto(91); check("exp_91", 32'(expire), 32'b0111);
    check("busy_91", 32'(busy), 32'b1010);

    // Stop ch1
    goto(92);
    send(2'd1, 1'b0, 1'b0, 16'd0);
    check("stop_busy", 32'(busy), 32'b1000);

    // Start with period 0 on ch2 stays idle
    goto(95);
    send(2'd2, 1'b1, 1'b0, 16'd0);
    check("zero_period", 32'(busy), 32'b1000);
    goto(101); check("exp_101", 32'(expire), 32'd0);
    goto(111); check("stopped_no_exp", 32'(expire), 32'd0);
    check("busy_111", 32'(busy), 32'b1000);

    // Reset in the middle of ch3's count
    goto(115);
    reset = 1'b1;
    step();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(cfg_if.cfg_ready), 32'd0);
    check("midrst_expire", 32'(expire), 32'd0);
    step();
    check("midrst_ready2", 32'(cfg_if.cfg_ready), 32'd0);
    reset = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      check("post_rst_expire", 32'(expire), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      if (k == 10 || k == 20) check("post_rst_tick", 32'(base_tick), 32'd1);
    end

`ifdef TIMER_SCHED_STICKY_EN
    // Sticky flag: set beats a simultaneous ack, a later ack clears
    check("flag_clear", 32'(expire_flag), 32'd0);
    send(2'd0, 1'b1, 1'b0, 16'd1);
    goto(30);
    check("st_tick", 32'(base_tick), 32'd1);
    step();
    check("st_expire", 32'(expire), 32'b0001);
    flag_ack = 4'b0001;
    step();
    check("st_set_wins", 32'(expire_flag), 32'b0001);
    flag_ack = 4'b0000;
    step();
    check("st_hold", 32'(expire_flag), 32'b0001);
    flag_ack = 4'b0001;
    step();
    check("st_ack", 32'(expire_flag), 32'd0);
    flag_ack = 4'b0000;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
